window_agc_ctrl: RTL
====================

Name: window_agc_ctrl

Overview:
- Automatic gain controller for the 20-bit to 8-bit window selector. It drives the selector's shift index (0..12) that picks the window sample_in[shift+7:shift].
- Monitors the full-width 20-bit sample stream over fixed-length frames, then steps the shift up on overflow or down on under-use.
- A manual step mode replaces the direct switch-driven stepping.
- Sits between the TDC sample source and the window selector, in the clk domain.

Parameters:
- FRAME_LEN, 1024: dval samples per measurement frame (≥2).
- OVF_THR, 4: a frame with ovf_cnt > OVF_THR steps the shift up.
- SETTLE_LEN, 16: dval samples discarded after any shift change.
- SHIFT_MAX, 12: maximum shift index.
- SHIFT_INIT, 5: shift after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- dval  in  1  sample-valid strobe, clk-synchronous, one cycle per sample.
- sample_in  in  20  unsigned sample, valid when dval=1.
- auto_en  in  1  1 = automatic control, 0 = manual.
- man_up  in  1  one-cycle pulse: manual shift+1.
- man_dn  in  1  one-cycle pulse: manual shift-1.
- shift_out  out  4  registered shift index, 0..SHIFT_MAX.
- shift_upd  out  1  one-cycle pulse on the cycle shift_out takes a new value.
- frame_done  out  1  one-cycle pulse when a frame is evaluated.
- ovf_flag  out  1  result of the last evaluated frame: 1 if ovf_cnt > 0.

Behaviour:
- Reset (rst=0 at a clk edge):
  - shift_out=SHIFT_INIT; shift_upd, frame_done and ovf_flag = 0.
  - All counters and the peak register are cleared.
  - State = IDLE. Reset applies mid-frame without exception.
- States: IDLE, ACCUM, DECIDE, SETTLE.
- IDLE:
  - If auto_en=1, go to ACCUM next cycle with counters cleared.
  - Otherwise handle manual pulses: man_up alone and shift<SHIFT_MAX → shift+1; man_dn alone and shift>0 → shift-1.
  - Any such change gives shift_upd=1 on the same edge that updates shift_out.
  - Both pulses in the same cycle are ignored. Saturated requests are ignored with no shift_upd.
  - Manual pulses are ignored in all other states.
- ACCUM: on each dval=1:
  - smp_cnt+1.
  - peak = max(peak, sample_in).
  - If (sample_in >> (shift_out+8)) != 0, ovf_cnt+1, saturating at all-ones.
  - On the edge accepting sample number FRAME_LEN, go to DECIDE.
- DECIDE (exactly one cycle):
  - frame_done=1; ovf_flag = (ovf_cnt != 0).
  - If ovf_cnt > OVF_THR and shift < SHIFT_MAX: next edge shift+1, shift_upd=1, go to SETTLE.
  - Else if peak < 2^(shift_out+6) and shift > 0: next edge shift-1, shift_upd=1, go to SETTLE.
  - Else: hold the shift and go to ACCUM.
  - Counters and peak clear on leaving DECIDE.
  - A dval arriving during DECIDE is dropped.
- SETTLE:
  - Count SETTLE_LEN dval samples without accumulating, then go to ACCUM.
  - If SETTLE_LEN=0, go to ACCUM directly.
- auto_en falling in any non-IDLE state: go to IDLE next edge, counters cleared, shift_out held, no frame_done.
- Arithmetic:
  - Comparisons are unsigned.
  - shift_out+8 ≤ 20, so the overflow mask is never out of range.
  - Compute 2^(shift+6) at ≥19 bits.
  - smp_cnt width = clog2(FRAME_LEN+1); ovf_cnt has the same width.
- Latency: the shift change is visible 2 clk after the last frame sample's edge (DECIDE, then the update edge).

Decomposition:
- Shared package window_agc_pkg: state enum, SHIFT_W=4, SAMPLE_W=20, WIN_W=8.
- One natural sub-module, frame_stats: smp_cnt, ovf_cnt and peak, with clear and enable inputs and a frame-complete output.
- The FSM and the shift register stay in the top level.

Test Plan:
- Reset release with auto_en=0 → shift_out=5, all pulses 0; man_up×8 → shift 12, exactly 7 shift_upd pulses, the 8th ignored.
- auto_en=1, shift=5, FRAME_LEN=16, 16 samples of 0x02000 (bit 13 set) → ovf_cnt=16>4; frame_done, then shift_out=6 with shift_upd 2 clk after the 16th dval; ovf_flag=1.
- shift=6, all samples 0x00FFF (<2^12) → shift steps to 5 after the frame; then with peak 0x00FFF ≥2^11, the shift holds at 5.
- After a shift change, first SETTLE_LEN=16 samples are huge (0xFFFFF) then small → the huge samples do not count; only the next frame is evaluated.
- auto_en dropped mid-ACCUM, then man_up and man_dn in the same cycle → IDLE, shift unchanged, no shift_upd, no frame_done.
- rst=0 asserted during SETTLE with shift=9 → next edge shift_out=5, state IDLE, counters 0.

Source files
------------

// File: rtl/window_agc_pkg.sv
// Shared types and constants for the window AGC controller.
// Provides the FSM state enum, bus widths and the under-use threshold helper.
package window_agc_pkg;

  localparam int SHIFT_W  = 4;
  localparam int SAMPLE_W = 20;
  localparam int WIN_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DECIDE,
    ST_SETTLE
  } agc_state_e;

  // 2^(shift+6): a frame peaking below this uses
  // less than the top two bits of the window.
  function automatic logic [SAMPLE_W-1:0] lo_limit(
    input logic [SHIFT_W-1:0] s
  );
    logic [SAMPLE_W-1:0] one;
    one = SAMPLE_W'(1);
    return one << ({1'b0, s} + 5'(WIN_W - 2));
  endfunction

endpackage

// File: rtl/window_agc_ctrl_frame_stats.sv
// Per-frame statistics: sample count, overflow count and peak.
// Ports: clk/rst, clr/en controls, sample_in, shift, ovf_cnt, peak, frame_last.
module window_agc_ctrl_frame_stats
  import window_agc_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SHIFT_W-1:0]  shift,
  output logic [CW-1:0]       ovf_cnt,
  output logic [SAMPLE_W-1:0] peak,
  output logic                frame_last
);

  logic [CW-1:0]       smp_cnt_q, smp_cnt_d;
  logic [CW-1:0]       ovf_cnt_q, ovf_cnt_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [4:0]          ovf_sh;
  logic                ovf_hit;

  // Any bit above the selected window means overflow.
  assign ovf_sh  = {1'b0, shift} + 5'(WIN_W);
  assign ovf_hit = (sample_in >> ovf_sh) != '0;

  always_comb begin
    smp_cnt_d = smp_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    peak_d    = peak_q;
    if (clr) begin
      smp_cnt_d = '0;
      ovf_cnt_d = '0;
      peak_d    = '0;
    end else if (en) begin
      smp_cnt_d = smp_cnt_q + CW'(1);
      if (sample_in > peak_q) begin
        peak_d = sample_in;
      end
      if (ovf_hit && (ovf_cnt_q != '1)) begin
        ovf_cnt_d = ovf_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_cnt_q <= '0;
      ovf_cnt_q <= '0;
      peak_q    <= '0;
    end else begin
      smp_cnt_q <= smp_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      peak_q    <= peak_d;
    end
  end

  assign ovf_cnt    = ovf_cnt_q;
  assign peak       = peak_q;
  assign frame_last = en && !clr
                    && (smp_cnt_q == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/window_agc_ctrl.sv
// Automatic gain control for the 20-to-8 bit window selector shift index.
// Ports: clk/rst, dval/sample_in, auto_en, man_up/man_dn, shift_out, shift_upd, frame_done, ovf_flag.
module window_agc_ctrl
  import window_agc_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned OVF_THR    = 4,
  parameter int unsigned SETTLE_LEN = 16,
  parameter int unsigned SHIFT_MAX  = 12,
  parameter int unsigned SHIFT_INIT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dval,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                auto_en,
  input  logic                man_up,
  input  logic                man_dn,
  output logic [SHIFT_W-1:0]  shift_out,
  output logic                shift_upd,
  output logic                frame_done,
  output logic                ovf_flag
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam int unsigned SW =
    (SETTLE_LEN < 1) ? 1 : $clog2(SETTLE_LEN + 1);

  agc_state_e          state_q, state_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic                shift_upd_q, shift_upd_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [SW-1:0]       settle_q, settle_d;

  logic                st_clr, st_en, frame_last;
  logic [CW-1:0]       ovf_cnt;
  logic [SAMPLE_W-1:0] peak;

  logic                at_max, at_min;
  logic                man_inc, man_dec;
  logic                over_thr, under_use;
  logic                settle_last;
  agc_state_e          after_step;

  // Statistics only run in ACCUM; leaving ACCUM
  // (or losing auto_en) wipes them for the next frame.
  assign st_clr = (state_q != ST_ACCUM) || !auto_en;
  assign st_en  = dval && (state_q == ST_ACCUM);

  window_agc_ctrl_frame_stats #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .clr        (st_clr),
    .en         (st_en),
    .sample_in  (sample_in),
    .shift      (shift_q),
    .ovf_cnt    (ovf_cnt),
    .peak       (peak),
    .frame_last (frame_last)
  );

  assign at_max    = shift_q == SHIFT_W'(SHIFT_MAX);
  assign at_min    = shift_q == '0;
  assign man_inc   = man_up && !man_dn && !at_max;
  assign man_dec   = man_dn && !man_up && !at_min;
  assign over_thr  = 32'(ovf_cnt) > OVF_THR;
  assign under_use = peak < lo_limit(shift_q);

  assign settle_last = dval
    && (settle_q == SW'(SETTLE_LEN - 1));
  assign after_step  = (SETTLE_LEN == 0)
    ? ST_ACCUM : ST_SETTLE;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    shift_upd_d = 1'b0;
    ovf_flag_d  = ovf_flag_q;
    settle_d    = '0;
    if ((state_q != ST_IDLE) && !auto_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (auto_en) begin
            state_d = ST_ACCUM;
          end else begin
            unique case (1'b1)
              man_inc: begin
                shift_d     = shift_q + SHIFT_W'(1);
                shift_upd_d = 1'b1;
              end
              man_dec: begin
                shift_d     = shift_q - SHIFT_W'(1);
                shift_upd_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_ACCUM: begin
          if (frame_last) begin
            state_d = ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          ovf_flag_d = ovf_cnt != '0;
          if (over_thr && !at_max) begin
            shift_d     = shift_q + SHIFT_W'(1);
            shift_upd_d = 1'b1;
            state_d     = after_step;
          end else if (under_use && !at_min) begin
            shift_d     = shift_q - SHIFT_W'(1);
            shift_upd_d = 1'b1;
            state_d     = after_step;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_SETTLE: begin
          if (settle_last) begin
            state_d = ST_ACCUM;
          end else if (dval) begin
            settle_d = settle_q + SW'(1);
          end else begin
            settle_d = settle_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= SHIFT_W'(SHIFT_INIT);
      shift_upd_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      shift_upd_q <= shift_upd_d;
      ovf_flag_q  <= ovf_flag_d;
      settle_q    <= settle_d;
    end
  end

  assign shift_out  = shift_q;
  assign shift_upd  = shift_upd_q;
  assign ovf_flag   = ovf_flag_q;
  // Suppressed if auto_en drops during the evaluation cycle.
  assign frame_done = (state_q == ST_DECIDE) && auto_en;

endmodule
